// File: rtl/fft_bitrev_serializer.sv
`default_nettype none
// ============================================================================
// Module      : fft_bitrev_serializer
// Description : Ping-pong reorder buffer that captures bit-reversed FFT frames
//               in parallel and streams them out serially in natural order.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_bitrev_serializer #(
    parameter  int N    = 8,
    parameter  int W    = 16,
    localparam int LOGN = $clog2(N)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [0:N-1][W-1:0]       in_r,
    input  logic [0:N-1][W-1:0]       in_i,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [W-1:0]       out_r,
    output logic signed [W-1:0]       out_i,
    output logic [LOGN-1:0]           out_idx,
    output logic                      out_last
);

    localparam logic [0:0]      c_st_empty = 1'b0;
    localparam logic [0:0]      c_st_full  = 1'b1;
    localparam logic [LOGN-1:0] c_last     = LOGN'(N - 1);

    logic [0:0]           r_state     [2];
    logic [0:0]           w_state_nxt [2];
    logic                 r_wr_sel;
    logic                 r_rd_sel;
    logic [LOGN-1:0]      r_cnt;
    logic [LOGN-1:0]      w_rev;
    logic [0:N-1][W-1:0]  r_bank_r [2];
    logic [0:N-1][W-1:0]  r_bank_i [2];
    logic                 w_accept;
    logic                 w_drain;
    logic                 w_last_drain;

    assign w_accept     = in_valid && in_ready;
    assign w_drain      = out_valid && out_ready;
    assign w_last_drain = w_drain && (r_cnt == c_last);

    for (genvar gi = 0; gi < LOGN; gi++) begin : g_bitrev
        assign w_rev[gi] = r_cnt[LOGN-1-gi];
    end

    // Per-bank occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state[0] <= c_st_empty;
            r_state[1] <= c_st_empty;
        end else begin
            r_state[0] <= w_state_nxt[0];
            r_state[1] <= w_state_nxt[1];
        end
    end

    // A bank can only be accepted into while empty and drained while full,
    // so accept and last-drain never target the same bank in one cycle.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_state_nxt[b] = r_state[b];
            case (r_state[b])
                c_st_empty: if (w_accept && (r_wr_sel == 1'(b)))
                                w_state_nxt[b] = c_st_full;
                c_st_full:  if (w_last_drain && (r_rd_sel == 1'(b)))
                                w_state_nxt[b] = c_st_empty;
                default:    w_state_nxt[b] = c_st_empty;
            endcase
        end
    end

    always_comb begin
        in_ready  = (r_state[r_wr_sel] == c_st_empty);
        out_valid = (r_state[r_rd_sel] == c_st_full);
        out_r     = r_bank_r[r_rd_sel][w_rev];
        out_i     = r_bank_i[r_rd_sel][w_rev];
        out_idx   = r_cnt;
        out_last  = out_valid && (r_cnt == c_last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_r[0] <= '0;
            r_bank_r[1] <= '0;
            r_bank_i[0] <= '0;
            r_bank_i[1] <= '0;
            r_wr_sel    <= 1'b0;
            r_rd_sel    <= 1'b0;
            r_cnt       <= '0;
        end else begin
            if (w_accept) begin
                r_bank_r[r_wr_sel] <= in_r;
                r_bank_i[r_wr_sel] <= in_i;
                r_wr_sel           <= ~r_wr_sel;
            end
            if (w_drain) begin
                if (r_cnt == c_last) begin
                    r_cnt    <= '0;
                    r_rd_sel <= ~r_rd_sel;
                end else begin
                    r_cnt <= r_cnt + LOGN'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_bitrev_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_bitrev_serializer
// Description : Self-checking bench for fft_bitrev_serializer (N=8, W=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_bitrev_serializer;

    localparam int N    = 8;
    localparam int W    = 16;
    localparam int LOGN = 3;

    typedef struct {
        logic [LOGN-1:0] idx;
        logic            last;
        logic [W-1:0]    r;
        logic [W-1:0]    i;
    } exp_t;

    typedef struct {
        logic [W-1:0]    in_r;
        logic [W-1:0]    in_i;
        logic [W-1:0]    exp_r;
        logic [W-1:0]    exp_i;
        logic [LOGN-1:0] exp_idx;
        logic            exp_last;
    } vec_t;

    logic                   clk       = 1'b0;
    logic                   rst_n     = 1'b0;
    logic                   in_valid  = 1'b0;
    logic                   out_ready = 1'b0;
    logic [0:N-1][W-1:0]    in_r      = '0;
    logic [0:N-1][W-1:0]    in_i      = '0;
    logic                   in_ready;
    logic                   out_valid;
    logic                   out_last;
    logic signed [W-1:0]    out_r;
    logic signed [W-1:0]    out_i;
    logic [LOGN-1:0]        out_idx;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_words  = 0;
    int          cyc      = 0;
    exp_t        sb[$];
    exp_t        e;
    int          acc_cyc[$];
    int          drain_cyc[$];
    logic        prev_stall = 1'b0;
    logic [63:0] prev_word  = '0;
    logic        rnd_done   = 1'b0;

    fft_bitrev_serializer #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_i      (in_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_i     (out_i),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic int tb_rev(input int k);
        int r = 0;
        for (int b = 0; b < LOGN; b++)
            if ((k >> b) & 1) r = r | (1 << (LOGN - 1 - b));
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard: push the natural-order words on accept, pop on each drain handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", 64'({out_valid, out_idx, out_last, out_r, out_i}), prev_word);
            if (!out_valid)
                chk("idle_last", 64'(out_last), 64'd0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_word: got idx %0d, expected no output", out_idx);
                end else begin
                    e = sb.pop_front();
                    chk("word", 64'({out_idx, out_last, out_r, out_i}),
                        64'({e.idx, e.last, e.r, e.i}));
                    n_words++;
                    if (out_last) drain_cyc.push_back(cyc + 1);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = 64'({out_valid, out_idx, out_last, out_r, out_i});
            if (in_valid && in_ready) begin
                for (int k = 0; k < N; k++) begin
                    e.idx  = LOGN'(k);
                    e.last = (k == N - 1);
                    e.r    = in_r[tb_rev(k)];
                    e.i    = in_i[tb_rev(k)];
                    sb.push_back(e);
                end
                acc_cyc.push_back(cyc + 1);
            end
        end
    end

    task automatic send_frame(input logic [0:N-1][W-1:0] fr, input logic [0:N-1][W-1:0] fi);
        in_r     = fr;
        in_i     = fi;
        in_valid = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        n_checks++;
        $display("FAIL accept_timeout: got no accept, expected in_ready within 1000 cycles");
    endtask

    task automatic wait_empty();
        for (int c = 0; c < 3000 && sb.size() != 0; c++) @(posedge clk);
        #1;
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_accept();
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) return;
        end
        n_checks++;
        $display("FAIL wait_accept: got no accept, expected one within 1000 cycles");
    endtask

    task automatic rand_frame(input int f, output logic [0:N-1][W-1:0] fr,
                              output logic [0:N-1][W-1:0] fi);
        for (int j = 0; j < N; j++) begin
            fr[j] = W'($urandom);
            fi[j] = W'($urandom);
        end
        if (f % 2 == 0) begin
            fr[0] = 16'h8000;
            fi[1] = 16'h7fff;
        end else begin
            fr[N-1] = 16'h7fff;
            fi[0]   = 16'h8000;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected completion before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t                tbl [N];
        logic [0:N-1][W-1:0] fr, fi, f1r, f1i, f2r, f2i, f3r, f3i;
        int                  nv;

        tbl[0] = '{16'd100,  16'sd0,  16'd100, 16'sd0,  3'd0, 1'b0};
        tbl[1] = '{16'd101, -16'sd1,  16'd104, -16'sd4, 3'd1, 1'b0};
        tbl[2] = '{16'd102, -16'sd2,  16'd102, -16'sd2, 3'd2, 1'b0};
        tbl[3] = '{16'd103, -16'sd3,  16'd106, -16'sd6, 3'd3, 1'b0};
        tbl[4] = '{16'd104, -16'sd4,  16'd101, -16'sd1, 3'd4, 1'b0};
        tbl[5] = '{16'd105, -16'sd5,  16'd105, -16'sd5, 3'd5, 1'b0};
        tbl[6] = '{16'd106, -16'sd6,  16'd103, -16'sd3, 3'd6, 1'b0};
        tbl[7] = '{16'd107, -16'sd7,  16'd107, -16'sd7, 3'd7, 1'b1};

        // Reset values
        #3;
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last",  64'(out_last),  64'd0);
        chk("rst_out_idx",   64'(out_idx),   64'd0);
        chk("rst_out_r",     64'($unsigned(out_r)), 64'd0);
        chk("rst_out_i",     64'($unsigned(out_i)), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Single frame, table driven
        for (int j = 0; j < N; j++) begin
            fr[j] = tbl[j].in_r;
            fi[j] = tbl[j].in_i;
        end
        out_ready = 1'b1;
        send_frame(fr, fi);
        in_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            chk("tbl_valid", 64'(out_valid), 64'd1);
            chk("tbl_r",     64'($unsigned(out_r)), 64'(tbl[k].exp_r));
            chk("tbl_i",     64'($unsigned(out_i)), 64'(tbl[k].exp_i));
            chk("tbl_idx",   64'(out_idx),  64'(tbl[k].exp_idx));
            chk("tbl_last",  64'(out_last), 64'(tbl[k].exp_last));
        end
        wait_empty();

        // Three frames back-to-back while the sink is stalled
        out_ready = 1'b0;
        acc_cyc.delete();
        drain_cyc.delete();
        rand_frame(0, f1r, f1i);
        rand_frame(1, f2r, f2i);
        rand_frame(2, f3r, f3i);
        fork
            begin
                send_frame(f1r, f1i);
                send_frame(f2r, f2i);
                send_frame(f3r, f3i);
                in_valid = 1'b0;
            end
            begin
                wait_accept();
                wait_accept();
                @(posedge clk);
                #1;
                repeat (3) begin
                    @(negedge clk);
                    chk("both_full_in_ready", 64'(in_ready), 64'd0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
                nv = 0;
                repeat (16) begin
                    @(negedge clk);
                    if (out_valid) nv++;
                end
                chk("b2b_no_gap", 64'(nv), 64'd16);
            end
        join
        wait_empty();
        chk("b2b_consecutive_accept", 64'(acc_cyc[1]), 64'(acc_cyc[0] + 1));
        chk("b2b_third_after_drain",  64'(acc_cyc[2]), 64'(drain_cyc[0] + 1));

        // Random sink backpressure over 20 frames
        n_words  = 0;
        rnd_done = 1'b0;
        fork
            begin
                for (int f = 0; f < 20; f++) begin
                    rand_frame(f, fr, fi);
                    send_frame(fr, fi);
                end
                in_valid = 1'b0;
                wait_empty();
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        chk("rand_word_count", 64'(n_words), 64'd160);

        // Continuous streaming over 10 frames
        @(posedge clk);
        #1 out_ready = 1'b1;
        n_words = 0;
        fork
            begin
                for (int f = 0; f < 10; f++) begin
                    rand_frame(f, fr, fi);
                    send_frame(fr, fi);
                end
                in_valid = 1'b0;
            end
            begin
                wait_accept();
                @(posedge clk);
                nv = 0;
                repeat (80) begin
                    @(negedge clk);
                    if (out_valid) nv++;
                end
                chk("stream_80_valid", 64'(nv), 64'd80);
            end
        join
        wait_empty();
        chk("stream_word_count", 64'(n_words), 64'd80);

        // Reset in the middle of a frame with a second frame queued
        out_ready = 1'b0;
        rand_frame(4, f1r, f1i);
        rand_frame(5, f2r, f2i);
        send_frame(f1r, f1i);
        send_frame(f2r, f2i);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            if (out_valid && out_idx == 3'd3) break;
        end
        chk("pre_rst_idx", 64'(out_idx), 64'd3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready",  64'(in_ready),  64'd1);
        chk("mid_rst_out_last",  64'(out_last),  64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        nv = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        chk("no_stale_words", 64'(nv), 64'd0);
        rand_frame(6, fr, fi);
        send_frame(fr, fi);
        in_valid = 1'b0;
        wait_empty();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_bitrev_serializer.md
# fft_bitrev_serializer

Output reorder buffer that sits directly downstream of the final `fft_stage`. It captures one complete parallel FFT frame of N complex words, which arrive in bit-reversed order from the decimation-in-frequency stages. It then streams the frame out one complex word per handshake in natural frequency order (X[0] … X[N-1]). Two ping-pong banks let one frame be captured while the previous frame is still draining.

## Interface
- `N`, 8: FFT size. Power of two, ≥ 2. `LOGN = $clog2(N)` is a derived localparam.
- `W`, 16: signed word width of the real and imaginary parts.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  a full parallel frame is present on `in_r`/`in_i`.
- `in_ready`  out  1  a bank is free; the frame is accepted when `in_valid && in_ready`.
- `in_r`, `in_i`  in  signed [W-1:0] [0:N-1]  last-stage outputs; element j holds bin bitrev(j).
- `out_valid`  out  1  `out_r`/`out_i`/`out_idx` are valid.
- `out_ready`  in  1  the sink accepts the word when `out_valid && out_ready`.
- `out_r`, `out_i`  out  signed [W-1:0]  bin value X[out_idx].
- `out_idx`  out  LOGN  natural-order bin index.
- `out_last`  out  1  high with the word where `out_idx == N-1`.

## Operation
- Storage: two banks, B0 and B1, each holding N×2×W bits. Each bank has a `full` flag.
- Control registers:
  - `wr_sel`: bank that receives the next frame.
  - `rd_sel`: bank currently being drained.
  - `cnt`: LOGN-bit read counter.
- Accept (`in_valid && in_ready`):
  - The whole array is copied verbatim into bank[`wr_sel`], with no reordering on write.
  - full[`wr_sel`] ← 1 and `wr_sel` toggles.
- `in_ready` = !full[`wr_sel`]. It is derived only from registered state, with no dependence on `in_valid`, `out_ready` or `out_valid`.
- `out_valid` = full[`rd_sel`].
- Read mux:
  - `out_r`/`out_i` = bank[`rd_sel`][bitrev(`cnt`)].
  - `out_idx` = `cnt`.
  - `out_last` = `out_valid && cnt == N-1`.
  - bitrev is a LOGN-bit reversal. For N=8, k = 0..7 maps to element 0, 4, 2, 6, 1, 5, 3, 7.
- Drain (`out_valid && out_ready`):
  - If `cnt < N-1`: `cnt` ← `cnt`+1.
  - If `cnt == N-1`: `cnt` ← 0, full[`rd_sel`] ← 0, `rd_sel` toggles.
- Bank state machine (per bank): EMPTY → FULL on accept into that bank; FULL → EMPTY on the last drain from that bank. No other transitions.
- No arithmetic is performed. Data passes bit-exact, with no scaling or saturation.
- `in_*` is ignored when `in_ready` = 0, and the sender must hold the frame. Out-of-range X/Z on `in_*` is not checked.
- `out_r`/`out_i`/`out_idx` while `out_valid` = 0 are don't-care for checking. The RTL drives the mux output.

## Timing
- Reset (async assert, sync release):
  - `full` = 0 for both banks; `wr_sel` = `rd_sel` = 0; `cnt` = 0; bank contents = 0.
  - Outputs in reset: `in_ready` = 1, `out_valid` = 0, `out_last` = 0, `out_idx` = 0, `out_r` = `out_i` = 0.
- Reset mid-frame: the partially drained frame and any queued frame are discarded. No words are emitted after reset until a new accept.
- Latency: a frame accepted at edge t gives `out_valid` = 1 after t if that bank is `rd_sel`. X[0] can be taken at edge t+1 and X[N-1] at edge t+N with `out_ready` held at 1.
- Throughput: one word per cycle sustained. Back-to-back frames stream with no bubble between X[N-1] of frame A and X[0] of frame B.
- Both banks full: `in_ready` = 0.
- Freeing a bank on the last drain at edge t:
  - `in_ready` rises after edge t, because the bank flags are registered.
  - There is no same-cycle bypass from drain to accept.
- Simultaneous accept and last-drain on different banks in the same cycle are both honoured.
- `out_ready` low: all outputs hold and `cnt` is frozen. `out_valid` never drops without a handshake.
- No combinational path from any input to any output.

## Test plan
- Reset, then one frame with N=8 and in_r[j] = 100+j, in_i[j] = −j; `out_ready` = 1.
  - Required: `in_ready` = 1 out of reset.
  - Required: out_r = 100, 104, 102, 106, 101, 105, 103, 107 on consecutive cycles; out_i is the matching negation of the element index; out_idx = 0..7; `out_last` only on idx 7.
- Three frames offered back-to-back with `in_valid` held high and `out_ready` held at 0.
  - Required: frames 1 and 2 accepted on consecutive edges; `in_ready` = 0 afterwards; frame 3 held.
  - Then `out_ready` = 1. Required: 16 words with no gap; frame 3 accepted one cycle after frame 1's idx-7 handshake.
- Random `out_ready` (≈50% duty) over 20 frames of random signed data including −32768 and 32767.
  - Required: every word matches the bit-reversal model; no loss or duplication; outputs stable while stalled.
- Continuous `in_valid` and `out_ready` = 1 over 10 frames.
  - Required: `out_valid` stays high for 80 consecutive cycles after the first accept.
- `rst_n` asserted at out_idx = 3 of frame 1 with frame 2 queued.
  - Required: immediate `out_valid` = 0 and `in_ready` = 1; no stale words appear after release.
